pc_unit: RTL and testbench

Parametrised program counter with a return-address stack (RAS), the successor to the fixed 32-bit PC in the APCPU fetch stage. Every cycle it applies one drive command (hold, increment, relative branch, absolute load, call, return) to the current fetch address and pulses a fetch strobe toward instruction memory whenever a new address is presented. Calls push the return address onto an internal circular stack; returns pop it. Overflow and underflow are reported as one-cycle flags.

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_ras.sv | 48 ++++
 rtl/pc_unit.sv | 88 ++++++++
 tb/tb_pc_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter drive command encoding, used by pc_unit, the decoder and the control unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'b000,
    PC_INC  = 3'b001,
    PC_REL  = 3'b010,
    PC_LOAD = 3'b011,
    PC_CALL = 3'b100,
    PC_RET  = 3'b101
  } pc_drive_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: write pointer plus occupancy count; a push when full
// overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp;
  logic [CW-1:0]     cnt;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign top      = mem[wp - PW'(1)];
  assign overflow = push & full;

  // When full, wp already points at the oldest slot, so a wrapping push overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      wp  <= wp - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with return-address stack, fetch strobe and overflow/underflow pulses.
import pc_pkg::*;

module pc_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       STEP       = 1,
  parameter int unsigned       RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCSet,
  input  logic [2:0]        PCDrive,
  output logic [ADDR_W-1:0] PCAddr,
  output logic              GetInstruction,
  output logic              RasOverflow,
  output logic              RasUnderflow
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  pc_drive_t         cmd;
  logic              fetched;
  logic [ADDR_W-1:0] next_pc;
  logic              advance;
  logic              push, pop, underflow;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty, ras_ovf;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (PCAddr + STEP_W),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty),
    .overflow (ras_ovf)
  );

  // Until the initial fetch has been issued every command is forced to HOLD,
  // which also keeps the stack untouched on that edge.
  always_comb begin
    cmd       = fetched ? pc_drive_t'(PCDrive) : PC_HOLD;
    next_pc   = PCAddr;
    advance   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    case (cmd)
      PC_INC:  begin next_pc = PCAddr + STEP_W; advance = 1'b1; end
      PC_REL:  begin next_pc = PCAddr + PCSet;  advance = 1'b1; end
      PC_LOAD: begin next_pc = PCSet;           advance = 1'b1; end
      PC_CALL: begin next_pc = PCSet;           advance = 1'b1; push = 1'b1; end
      PC_RET: begin
        if (ras_empty) begin
          underflow = 1'b1;
        end else begin
          next_pc = ras_top;
          advance = 1'b1;
          pop     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCAddr         <= RESET_ADDR;
      fetched        <= 1'b0;
      GetInstruction <= 1'b0;
      RasOverflow    <= 1'b0;
      RasUnderflow   <= 1'b0;
    end else begin
      fetched        <= 1'b1;
      PCAddr         <= next_pc;
      GetInstruction <= !fetched || advance;
      RasOverflow    <= ras_ovf;
      RasUnderflow   <= underflow;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed sequences plus random commands against a queue-based model.
module tb_pc_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCSet = '0;
  logic [2:0]  PCDrive = '0;
  logic [31:0] PCAddr;
  logic        GetInstruction, RasOverflow, RasUnderflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_gi, m_ov, m_un;
  logic [31:0] m_stack[$];

  pc_unit #(
    .ADDR_W     (32),
    .STEP       (1),
    .RAS_DEPTH  (DEPTH),
    .RESET_ADDR (32'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSet          (PCSet),
    .PCDrive        (PCDrive),
    .PCAddr         (PCAddr),
    .GetInstruction (GetInstruction),
    .RasOverflow    (RasOverflow),
    .RasUnderflow   (RasUnderflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, PCAddr, m_pc);
    check({tag, ".gi"}, 32'(GetInstruction), 32'(m_gi));
    check({tag, ".ovf"}, 32'(RasOverflow), 32'(m_ov));
    check({tag, ".unf"}, 32'(RasUnderflow), 32'(m_un));
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_started = 1'b0;
    m_gi = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic [2:0] d, input logic [31:0] s);
    m_gi = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
      m_gi = 1'b1;
      return;
    end
    case (d)
      3'd1: begin m_pc = m_pc + 32'd1; m_gi = 1'b1; end
      3'd2: begin m_pc = m_pc + s;     m_gi = 1'b1; end
      3'd3: begin m_pc = s;            m_gi = 1'b1; end
      3'd4: begin
        m_stack.push_back(m_pc + 32'd1);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ov = 1'b1;
        end
        m_pc = s;
        m_gi = 1'b1;
      end
      3'd5: begin
        if (m_stack.size() == 0) m_un = 1'b1;
        else begin
          m_pc = m_stack.pop_back();
          m_gi = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // Drive a command, clock it in, and compare 1 time unit after the edge.
  task automatic step(input string tag, input logic [2:0] d, input logic [31:0] s);
    PCDrive = d;
    PCSet   = s;
    @(posedge clk);
    model_step(d, s);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // first fetch, then increments and hold
    step("first", 3'd1, 32'd0);
    check("first.pc_const", PCAddr, 32'd0);
    step("inc1", 3'd1, 32'd0);
    step("inc2", 3'd1, 32'd0);
    step("inc3", 3'd1, 32'd0);
    check("inc3.pc_const", PCAddr, 32'd3);
    step("hold", 3'd0, 32'd77);

    // load, negative relative branch, wrap
    step("load", 3'd3, 32'd5791);
    step("rel", 3'd2, 32'hFFFF_FFF0);
    check("rel.pc_const", PCAddr, 32'd5775);
    step("loadmax", 3'd3, 32'hFFFF_FFFF);
    step("wrap", 3'd1, 32'd0);
    step("loadsame", 3'd3, 32'd0);

    // call / inc / return
    step("ld100", 3'd3, 32'd100);
    step("call", 3'd4, 32'd7894);
    step("cinc", 3'd1, 32'd0);
    step("ret", 3'd5, 32'd0);
    check("ret.pc_const", PCAddr, 32'd101);

    // nested calls overflowing the stack, then unwinding to underflow
    for (int unsigned i = 1; i <= 5; i++) begin
      step("nld", 3'd3, 32'(10 * i));
      step("ncall", 3'd4, 32'(1000 + i));
    end
    for (int unsigned i = 0; i < 5; i++) step("nret", 3'd5, 32'd0);

    // back-to-back call/return
    step("bld", 3'd3, 32'd200);
    step("bcall", 3'd4, 32'd33);
    step("bret", 3'd5, 32'd0);

    // reset discards stacked entries
    step("rcall1", 3'd4, 32'd300);
    step("rcall2", 3'd4, 32'd400);
    apply_reset("midrst");
    step("rfirst", 3'd5, 32'd0);
    step("rret", 3'd5, 32'd0);

    // reserved encodings leave pc and stack alone
    step("sld", 3'd3, 32'd500);
    step("scall", 3'd4, 32'd600);
    step("res6", 3'd6, 32'd33);
    step("res7", 3'd7, 32'd33);
    step("sret", 3'd5, 32'd0);
    step("sret2", 3'd5, 32'd0);

    // random traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [2:0]  d;
      logic [31:0] s;
      if ($urandom_range(0, 199) == 0) apply_reset("rrst");
      d = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) d = 3'($urandom_range(4, 5));
      case ($urandom_range(0, 2))
        0: s = $urandom;
        1: s = 32'($urandom_range(0, 64));
        default: s = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
      endcase
      step("rnd", d, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
